// File: rtl/fp_align_unpack_if.sv
// fp_align_unpack_if: operand handshake and unpacked/aligned result bundle for the FP adder front end
interface fp_align_unpack_if;
  logic in_valid, in_ready;
  logic [31:0] A, B;
  logic out_valid, out_ready;
  logic alignedSign, carryOut, signA, signB;
  logic [7:0] exponentOut;
  logic [31:0] alignedResult;
  logic ANaN, BNaN, Ainf, Binf, Azero, Bzero;
  modport master(output in_valid, A, B, out_ready,
                 input in_ready, out_valid, alignedSign, exponentOut, alignedResult, carryOut,
                 signA, signB, ANaN, BNaN, Ainf, Binf, Azero, Bzero);
  modport slave(input in_valid, A, B, out_ready,
                output in_ready, out_valid, alignedSign, exponentOut, alignedResult, carryOut,
                signA, signB, ANaN, BNaN, Ainf, Binf, Azero, Bzero);
endinterface

// File: rtl/fp_align_unpack.sv
// fp_align_unpack: unpack two singles, serially align the smaller significand with sticky jamming,
// then add/subtract magnitudes and hold the result until the normalize stage takes it
module fp_align_unpack #(
  parameter int MAX_SHIFT = 31
) (
  input logic clk,
  input logic reset,
  fp_align_unpack_if.slave bus
);
  localparam logic [2:0] S_IDLE = 3'd0, S_UNPACK = 3'd1, S_SHIFT = 3'd2, S_ADD = 3'd3, S_HOLD = 3'd4;
  logic [2:0] r_state;
  logic [31:0] r_a, r_b, r_sig_l, r_sig_s, r_res;
  logic [7:0] r_n, r_exp_l, r_expo;
  logic r_sign_l, r_sign_s, r_sign_a, r_sign_b, r_sign, r_carry;
  logic [5:0] r_flags;
  logic [7:0] w_exp_a, w_exp_b, w_eff_a, w_eff_b, w_d, w_n;
  logic [31:0] w_sig_a, w_sig_b;
  logic [5:0] w_flags;
  logic w_a_big;
  logic [32:0] w_sum, w_dif, w_res;
  assign w_exp_a = r_a[30:23];
  assign w_exp_b = r_b[30:23];
  assign w_eff_a = (w_exp_a == 8'd0) ? 8'd1 : w_exp_a;
  assign w_eff_b = (w_exp_b == 8'd0) ? 8'd1 : w_exp_b;
  assign w_sig_a = {|w_exp_a, r_a[22:0], 8'h00};
  assign w_sig_b = {|w_exp_b, r_b[22:0], 8'h00};
  assign w_flags = {&w_exp_a && |r_a[22:0], &w_exp_b && |r_b[22:0],
                    &w_exp_a && ~|r_a[22:0], &w_exp_b && ~|r_b[22:0],
                    ~|w_exp_a && ~|r_a[22:0], ~|w_exp_b && ~|r_b[22:0]};
  assign w_a_big = (w_eff_a > w_eff_b) || (w_eff_a == w_eff_b && w_sig_a >= w_sig_b);
  assign w_d = w_a_big ? w_eff_a - w_eff_b : w_eff_b - w_eff_a;
  // any special operand skips alignment; normalize resolves those cases
  assign w_n = (|w_flags) ? 8'd0 : (w_d > 8'(MAX_SHIFT)) ? 8'(MAX_SHIFT) : w_d;
  assign w_sum = {1'b0, r_sig_l} + {1'b0, r_sig_s};
  assign w_dif = {1'b0, r_sig_l - r_sig_s};
  assign w_res = (r_sign_l == r_sign_s) ? w_sum : w_dif;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_a <= '0;
      r_b <= '0;
      r_sig_l <= '0;
      r_sig_s <= '0;
      r_res <= '0;
      r_n <= '0;
      r_exp_l <= '0;
      r_expo <= '0;
      r_sign_l <= 1'b0;
      r_sign_s <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_sign <= 1'b0;
      r_carry <= 1'b0;
      r_flags <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.in_valid) begin
          r_a <= bus.A;
          r_b <= bus.B;
          r_state <= S_UNPACK;
        end
        S_UNPACK: begin
          r_flags <= w_flags;
          r_sign_a <= r_a[31];
          r_sign_b <= r_b[31];
          r_sign_l <= w_a_big ? r_a[31] : r_b[31];
          r_sign_s <= w_a_big ? r_b[31] : r_a[31];
          r_sig_l <= w_a_big ? w_sig_a : w_sig_b;
          r_sig_s <= w_a_big ? w_sig_b : w_sig_a;
          r_exp_l <= w_a_big ? w_eff_a : w_eff_b;
          r_n <= w_n;
          r_state <= (w_n != 8'd0) ? S_SHIFT : S_ADD;
        end
        S_SHIFT: begin
          r_sig_s <= {1'b0, r_sig_s[31:2], |r_sig_s[1:0]};
          r_n <= r_n - 8'd1;
          if (r_n == 8'd1) r_state <= S_ADD;
        end
        S_ADD: begin
          {r_carry, r_res} <= w_res;
          r_sign <= (r_sign_l != r_sign_s && w_dif == 33'd0) ? 1'b0 : r_sign_l;
          r_expo <= r_exp_l;
          r_state <= S_HOLD;
        end
        S_HOLD: if (bus.out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign bus.in_ready = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_HOLD);
  assign bus.alignedSign = r_sign;
  assign bus.exponentOut = r_expo;
  assign bus.alignedResult = r_res;
  assign bus.carryOut = r_carry;
  assign bus.signA = r_sign_a;
  assign bus.signB = r_sign_b;
  assign {bus.ANaN, bus.BNaN, bus.Ainf, bus.Binf, bus.Azero, bus.Bzero} = r_flags;
endmodule

// File: tb/tb_fp_align_unpack.sv
// tb_fp_align_unpack: scoreboard bench for the FP adder align/unpack front end
module tb_fp_align_unpack;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  fp_align_unpack_if bus();
  fp_align_unpack dut(.clk(clk), .reset(reset), .bus(bus));
  typedef struct {
    logic [31:0] a, b;
    int lat;
    logic [49:0] obs;
  } exp_t;
  exp_t tbl[11];
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  function automatic logic [49:0] obs_now();
    return {bus.alignedSign, bus.exponentOut, bus.carryOut, bus.alignedResult, bus.signA, bus.signB,
            bus.ANaN, bus.BNaN, bus.Ainf, bus.Binf, bus.Azero, bus.Bzero};
  endfunction
  task automatic send(input logic [31:0] a, b, input bit rel, output logic [49:0] got, output int lat);
    int t = 0;
    while (!bus.in_ready && t < 100) begin @(negedge clk); t++; end
    bus.A = a;
    bus.B = b;
    bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    bus.A = $urandom;
    bus.B = $urandom;
    lat = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid) break;
      if (lat >= 60) begin lat = -1; break; end
      @(posedge clk);
      lat++;
    end
    got = obs_now();
    if (rel) begin
      bus.out_ready = 1;
      @(posedge clk); #1;
      bus.out_ready = 0;
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.in_ready, bus.out_valid, obs_now()} !== {2'b10, 50'd0}) begin
      n_bad++;
      $display("FAIL reset got rdy=%b vld=%b obs=%h exp rdy=1 vld=0 obs=0", bus.in_ready, bus.out_valid, obs_now());
    end
    reset = 0;
  endtask
  task automatic run_list(input string tag, input int lo, input int hi);
    logic [49:0] got;
    int lat;
    exp_t e;
    for (int i = lo; i <= hi; i++) begin
      q.push_back(tbl[i]);
      send(tbl[i].a, tbl[i].b, 1, got, lat);
      e = q.pop_front();
      n_cmp += 2;
      if (got !== e.obs) begin
        n_bad++;
        $display("FAIL %s[%0d] fields got %h exp %h", tag, i, got, e.obs);
      end
      if (lat !== e.lat) begin
        n_bad++;
        $display("FAIL %s[%0d] latency got %0d exp %0d", tag, i, lat, e.lat);
      end
    end
  endtask
  task automatic test_arith();
    run_list("arith", 0, 3);
    run_list("arith", 6, 9);
  endtask
  task automatic test_specials();
    run_list("special", 4, 5);
    run_list("special", 10, 10);
  endtask
  task automatic test_backpressure();
    logic [49:0] got;
    int lat;
    exp_t e;
    q.push_back(tbl[8]);
    send(tbl[8].a, tbl[8].b, 0, got, lat);
    e = q.pop_front();
    n_cmp += 2;
    if (got !== e.obs) begin n_bad++; $display("FAIL bp fields got %h exp %h", got, e.obs); end
    if (lat !== e.lat) begin n_bad++; $display("FAIL bp latency got %0d exp %0d", lat, e.lat); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.out_valid, bus.in_ready, obs_now()} !== {2'b10, e.obs}) begin
        n_bad++;
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b obs=%h exp vld=1 rdy=0 obs=%h", i, bus.out_valid, bus.in_ready, obs_now(), e.obs);
      end
    end
    bus.out_ready = 1;
    @(posedge clk); #1;
    bus.out_ready = 0;
    @(negedge clk);
    n_cmp++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", bus.out_valid, bus.in_ready);
    end
  endtask
  task automatic test_reset_midshift();
    bus.A = 32'h3F800000;
    bus.B = 32'h00000001;
    bus.in_valid = 1;
    @(posedge clk); #1;
    bus.in_valid = 0;
    repeat (10) @(posedge clk);
    #2 reset = 1;
    #1;
    n_cmp++;
    if ({bus.out_valid, bus.in_ready, obs_now()} !== {2'b01, 50'd0}) begin
      n_bad++;
      $display("FAIL reset_midshift got vld=%b rdy=%b obs=%h exp vld=0 rdy=1 obs=0", bus.out_valid, bus.in_ready, obs_now());
    end
    @(negedge clk);
    reset = 0;
    run_list("after_reset", 0, 0);
  endtask
  task automatic test_back_to_back();
    run_list("b2b", 9, 9);
    run_list("b2b", 7, 7);
    run_list("b2b", 1, 1);
  endtask
  initial begin
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.A = '0;
    bus.B = '0;
    tbl[0]  = '{32'h3F800000, 32'h3F800000, 2,  {1'b0, 8'h7F, 1'b1, 32'h00000000, 2'b00, 6'b000000}};
    tbl[1]  = '{32'h3F800000, 32'h33800000, 26, {1'b0, 8'h7F, 1'b0, 32'h80000080, 2'b00, 6'b000000}};
    tbl[2]  = '{32'h3F800000, 32'h00000001, 33, {1'b0, 8'h7F, 1'b0, 32'h80000001, 2'b00, 6'b000000}};
    tbl[3]  = '{32'h3F800000, 32'hBF800000, 2,  {1'b0, 8'h7F, 1'b0, 32'h00000000, 2'b01, 6'b000000}};
    tbl[4]  = '{32'h7F800000, 32'hFF800000, 2,  {1'b0, 8'hFF, 1'b0, 32'h00000000, 2'b01, 6'b001100}};
    tbl[5]  = '{32'h7FC00000, 32'h3F800000, 2,  {1'b0, 8'hFF, 1'b1, 32'h40000000, 2'b00, 6'b100000}};
    tbl[6]  = '{32'h3FC00000, 32'hBF800000, 2,  {1'b0, 8'h7F, 1'b0, 32'h40000000, 2'b01, 6'b000000}};
    tbl[7]  = '{32'hC0000000, 32'h3F800000, 3,  {1'b1, 8'h80, 1'b0, 32'h40000000, 2'b10, 6'b000000}};
    tbl[8]  = '{32'h3F800000, 32'h40000000, 3,  {1'b0, 8'h80, 1'b0, 32'hC0000000, 2'b00, 6'b000000}};
    tbl[9]  = '{32'h00000001, 32'h00000002, 2,  {1'b0, 8'h01, 1'b0, 32'h00000300, 2'b00, 6'b000000}};
    tbl[10] = '{32'h00000000, 32'h3F800000, 2,  {1'b0, 8'h7F, 1'b0, 32'h80000000, 2'b00, 6'b000010}};
    test_reset();
    test_arith();
    test_specials();
    test_backpressure();
    test_reset_midshift();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
